// File: rtl/scaledclock_pkg.sv
// scaledclock_pkg: receiver state encoding and default sizing constants.
package scaledclock_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} rx_state_t;
  localparam int DEF_CNT_W   = 28;
  localparam int DEF_TIMEOUT = 200_000_000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizer, optional 3-cycle stability filter (GLITCH_FILTER_EN), rising-edge pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic level;
  logic prev;
  always_ff @(posedge clock or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], async_level};
`ifdef GLITCH_FILTER_EN
  logic [1:0] run;
  logic filt;
  // filt follows the synchronized level only after it has differed for 3 samples
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      run  <= '0;
      filt <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == filt) run <= '0;
    else if (run == 2'd2) begin
      filt <= sync[SYNC_STAGES-1];
      run  <= '0;
    end else run <= run + 2'd1;
  assign level = filt;
`else
  assign level = sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) prev <= 1'b0;
    else prev <= level;
  assign rise = level & ~prev;
endmodule

// File: rtl/scaled_tick_receiver.sv
// scaled_tick_receiver: turns an async scaled clock into one-cycle ticks, measures its period, flags loss.
module scaled_tick_receiver
  import scaledclock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             scaled_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lost
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  rx_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, period_d;
  logic rise, tick_d, pv_d, lost_d, timed_out;
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .async_level(scaled_in),
    .rise(rise)
  );
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign timed_out = (cnt == TO_LAST);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      tick         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      tick         <= tick_d;
      period       <= period_d;
      period_valid <= pv_d;
      lost         <= lost_d;
    end
  always_comb begin
    state_d = state;
    if (!enable) state_d = IDLE;
    else
      case (state)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: state_d = rise ? LOCKED : ACQUIRE;
        LOCKED:  state_d = (!rise && timed_out) ? LOST : LOCKED;
        LOST:    state_d = rise ? LOCKED : LOST;
      endcase
  end
  // an edge on the timeout cycle is taken as a measurement, not a loss
  always_comb begin
    cnt_d    = '0;
    tick_d   = 1'b0;
    period_d = period;
    pv_d     = period_valid;
    lost_d   = lost;
    if (!enable) begin
      pv_d   = 1'b0;
      lost_d = 1'b0;
    end else
      case (state)
        IDLE: begin
          pv_d   = 1'b0;
          lost_d = 1'b0;
        end
        ACQUIRE: tick_d = rise;
        LOCKED:
          if (rise) begin
            tick_d   = 1'b1;
            period_d = cnt_inc;
            pv_d     = 1'b1;
          end else if (timed_out) begin
            lost_d = 1'b1;
            pv_d   = 1'b0;
          end else cnt_d = cnt_inc;
        LOST:
          if (rise) begin
            tick_d = 1'b1;
            lost_d = 1'b0;
          end
      endcase
  end
endmodule

// File: tb/tb_scaled_tick_receiver.sv
// tb_scaled_tick_receiver: directed vector table plus hand sequences for latency, timeout, enable and reset.
module tb_scaled_tick_receiver;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = 6;
  localparam int GLITCH_TICKS = 0;
`else
  localparam int LAT = 3;
  localparam int GLITCH_TICKS = 1;
`endif
  localparam int TO = 1000;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, scaled_in = 1'b0;
  logic tick, period_valid, lost;
  logic [27:0] period;
  int n_cmp = 0, n_err = 0, ticks = 0;
  logic last_tick = 1'b0;
  typedef struct {
    bit en;
    int hi, lo, reps, ex_ticks, ex_period;
    bit ex_valid, ex_lost;
  } vec_t;
  vec_t vecs[5];
  scaled_tick_receiver #(.SYNC_STAGES(2), .CNT_W(28), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .scaled_in(scaled_in),
    .tick(tick),
    .period(period),
    .period_valid(period_valid),
    .lost(lost)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // advance to the next falling edge and observe tick there
  task automatic cyc();
    @(negedge clock);
    if (tick) begin
      ticks++;
      chk("tick_width", int'(last_tick), 0);
    end
    last_tick = tick;
  endtask
  task automatic wait_tick(output int n);
    int t0 = ticks;
    n = 0;
    while (ticks == t0 && n < 2000) begin
      cyc();
      n++;
    end
  endtask
  task automatic check_outs(input string tag, input int p, input int pv, input int l);
    chk({tag, "_period"}, int'(period), p);
    chk({tag, "_valid"}, int'(period_valid), pv);
    chk({tag, "_lost"}, int'(lost), l);
  endtask
  initial begin
    int n, t0;
    vecs[0] = '{1'b1, 50, 50, 1, 1, 100, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 20, 20, 3, 3, 40, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 20, 20, 2, 0, 40, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 20, 20, 1, 1, 40, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 30, 30, 2, 2, 60, 1'b1, 1'b0};
    repeat (3) cyc();
    chk("reset_tick", int'(tick), 0);
    check_outs("reset", 0, 0, 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) cyc();
    scaled_in = 1'b1;
    wait_tick(n);
    chk("first_latency", n, LAT);
    check_outs("acquire", 0, 0, 0);
    repeat (50 - n) cyc();
    scaled_in = 1'b0;
    repeat (50) cyc();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        enable = 1'b0;
        cyc();
        check_outs("disable_next", 40, 0, 0);
      end
      enable = vecs[i].en;
      t0 = ticks;
      for (int r = 0; r < vecs[i].reps; r++) begin
        scaled_in = 1'b1;
        repeat (vecs[i].hi) cyc();
        scaled_in = 1'b0;
        repeat (vecs[i].lo) cyc();
      end
      chk($sformatf("vec%0d_ticks", i), ticks - t0, vecs[i].ex_ticks);
      check_outs($sformatf("vec%0d", i), vecs[i].ex_period, int'(vecs[i].ex_valid), int'(vecs[i].ex_lost));
    end
    scaled_in = 1'b1;
    wait_tick(n);
    chk("relock_latency", n, LAT);
    n = 0;
    while (!lost && n < TO + 100) begin
      cyc();
      n++;
    end
    chk("lost_delay", n, TO);
    check_outs("lost", 60, 0, 1);
    scaled_in = 1'b0;
    repeat (5) cyc();
    scaled_in = 1'b1;
    wait_tick(n);
    chk("lost_recover_latency", n, LAT);
    check_outs("recovered", 60, 0, 0);
    repeat (10) cyc();
    scaled_in = 1'b0;
    repeat (TO - LAT - 10) cyc();
    scaled_in = 1'b1;
    wait_tick(n);
    chk("edge_on_timeout_latency", n, LAT);
    check_outs("edge_on_timeout", TO, 1, 0);
    repeat (10) cyc();
    scaled_in = 1'b0;
    repeat (10) cyc();
    t0 = ticks;
    scaled_in = 1'b1;
    repeat (2) cyc();
    scaled_in = 1'b0;
    repeat (12) cyc();
    chk("pulse2_ticks", ticks - t0, GLITCH_TICKS);
    t0 = ticks;
    scaled_in = 1'b1;
    repeat (3) cyc();
    scaled_in = 1'b0;
    repeat (12) cyc();
    chk("pulse3_ticks", ticks - t0, 1);
    chk("lost_after_pulses", int'(lost), 0);
    scaled_in = 1'b1;
    repeat (5) cyc();
    reset = 1'b1;
    #1;
    chk("midreset_tick", int'(tick), 0);
    check_outs("midreset", 0, 0, 0);
    cyc();
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
